des_sbox_sequencer: RTL and testbench
=====================================

// Module: des_sbox_sequencer
// PURPOSE
//  Serialises the DES f-function substitution stage onto a single shared S-box lookup port.
//  Accepts one 48-bit post-key-XOR word per transaction and issues eight 6-bit lookups (S1..S8) in order.
//  Packs the eight 4-bit results into a 32-bit word and returns it via a valid/ready handshake.
//  Sits between the round datapath (E-expansion XOR) and the P-permutation in the area-reduced DES core.
// PARAMETERS
//  PIPE_LOOKUP  0  0: sbox_out is combinational, sampled in the same cycle it is issued; 1: sampled one cycle later
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  in_valid   in   1       in_data valid
//  in_ready   out  1       sequencer can accept a new word
//  in_data    in   [1:48]  DES bit numbering; chunk k (1..8) = in_data[6k-5:6k]
//  sbox_req   out  1       a lookup is being issued this cycle
//  sbox_sel   out  [2:0]   S-box index minus 1 (0 = S1 .. 7 = S8)
//  sbox_in    out  [1:6]   6-bit chunk for the selected S-box
//  sbox_out   in   [1:4]   lookup result from the shared S-box
//  out_valid  out  1       out_data holds a complete result
//  out_ready  in   1       downstream accepts out_data
//  out_data   out  [1:32]  S_k result at out_data[4k-3:4k]
//  busy       out  1       a transaction is in progress (state != IDLE)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, sbox_req=0, sbox_sel=0, sbox_in=0, out_data=0, busy=0.
//  States: IDLE -> ISSUE -> (DRAIN if PIPE_LOOKUP=1) -> DONE -> IDLE.
//  IDLE: in_ready=1. On in_valid&&in_ready, latch in_data, set idx=0, go to ISSUE. in_data is ignored at all other times.
//  ISSUE: sbox_req=1, sbox_sel=idx, sbox_in=chunk idx+1; idx increments each cycle; leave ISSUE after idx=7.
//  Capture when PIPE_LOOKUP=0: the result of lookup idx is written into out_data nibble idx+1 on the same edge.
//  Capture when PIPE_LOOKUP=1: the result is written one edge later. DRAIN lasts 1 cycle, with sbox_req=0, and captures the result of S8.
//  Latency: out_valid rises exactly 8+PIPE_LOOKUP cycles after the accepting edge.
//  DONE: out_valid=1; out_data is held stable while out_ready=0 (no limit on stall).
//  On out_valid&&out_ready, return to IDLE. in_ready rises the next cycle, so there is no same-cycle accept.
//   Throughput: one word per 10+PIPE_LOOKUP cycles at full rate.
//  sbox_sel/sbox_in hold their last values when sbox_req=0. The S-box consumer must only use them while sbox_req=1.
//  out_data nibbles not yet written hold the previous result. They are not cleared on accept, only by reset.
//  idx is 3 bits and never wraps within a transaction. The ISSUE exit is decoded from idx==7, not from overflow.
//  Reset mid-transaction aborts immediately: the partial result is discarded, and out_valid stays 0 after release.
//  in_valid held through DONE is not accepted until IDLE. No input word is lost or duplicated.
//  Any X on out_ready in IDLE/ISSUE is ignored. Only DONE samples it.
// TESTING
//  1 Reset: rst_n=0 for 3 cycles -> in_ready=1, out_valid=0, sbox_req=0, busy=0.
//  2 Bench muxes the real S1..S8 by sbox_sel. Send in_data=48'h0 -> out_data=32'hEFA72C4D.
//    out_valid rises 8 cycles after accept (PIPE_LOOKUP=0), 9 cycles (PIPE_LOOKUP=1).
//  3 Send in_data=48'hFFFFFFFFFFFF -> out_data=32'hD9CE3DCB.
//    sbox_sel sequence 0..7 with sbox_in=6'b111111 each cycle.
//  4 Backpressure: out_ready=0 for 20 cycles in DONE -> out_data and out_valid stable, in_ready=0.
//    Release -> in_ready=1 on the next cycle.
//  5 Abort: pulse rst_n low during the 4th ISSUE cycle -> all outputs at reset values.
//    A following 48'h0 transaction yields 32'hEFA72C4D.
//  6 Back-to-back: in_valid held high with 3 random words (checked against the S-box model).
//    3 results in order, each accept spaced 10+PIPE_LOOKUP cycles apart.

Source files
------------

// File: rtl/des_sbox_sequencer.sv
// des_sbox_sequencer: runs the eight DES S-box lookups of one f-function round
// through a single shared S-box port and packs the results into a 32-bit word.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   48-bit input handshake (post key-XOR word)
//   in_data[47:0]         DES bit n lives at index 48-n; chunk k (S_k) = in_data[53-6k -: 6]
//   sbox_req              a lookup is issued this cycle
//   sbox_sel[2:0]         S-box index minus one (0 = S1 .. 7 = S8)
//   sbox_in[5:0]          6-bit chunk for the selected S-box (bit 5 = DES bit 1)
//   sbox_out[3:0]         result returned by the shared S-box
//   out_valid / out_ready 32-bit result handshake
//   out_data[31:0]        S_k result at out_data[35-4k -: 4] (S1 in the top nibble)
//   busy                  a transaction is in progress
//
// PIPE_LOOKUP = 0: sbox_out is sampled in the cycle the lookup is issued.
// PIPE_LOOKUP = 1: sbox_out is sampled one cycle later; a DRAIN cycle collects S8.
module des_sbox_sequencer #(
    parameter int unsigned PIPE_LOOKUP = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] in_data,
    output logic        sbox_req,
    output logic [2:0]  sbox_sel,
    output logic [5:0]  sbox_in,
    input  logic [3:0]  sbox_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);

    localparam int unsigned IN_W   = 48;
    localparam int unsigned OUT_W  = 32;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned CHK_W  = 6;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned NLOOK  = 8;
    localparam bit          PIPE   = (PIPE_LOOKUP != 0);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NLOOK - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d, idx_nxt;
    logic [IN_W-1:0]    data_q, data_d;
    logic [OUT_W-1:0]   res_d;
    logic [IDX_W-1:0]   sel_d;
    logic [CHK_W-1:0]   sin_d;
    logic               cap_en;
    logic [IDX_W-1:0]   cap_idx;
    logic [CHK_W-1:0]   chunks [NLOOK];

    // Next-state, lookup issue and result capture
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        res_d   = out_data;
        sel_d   = sbox_sel;
        sin_d   = sbox_in;
        cap_en  = 1'b0;
        cap_idx = idx_q;
        idx_nxt = IDX_W'(idx_q + IDX_W'(1));

        for (int k = 0; k < NLOOK; k++) begin
            chunks[k] = data_q[IN_W-1-CHK_W*k -: CHK_W];
        end

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    data_d  = in_data;
                    idx_d   = '0;
                    sel_d   = '0;
                    sin_d   = in_data[IN_W-1 -: CHK_W];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // With a pipelined S-box the result trails the request by one cycle,
                // so the first ISSUE cycle has nothing to capture yet.
                cap_en  = !PIPE || (idx_q != '0);
                cap_idx = PIPE ? IDX_W'(idx_q - IDX_W'(1)) : idx_q;
                if (idx_q == LAST_IDX) begin
                    state_d = PIPE ? DRAIN : DONE;
                end else begin
                    idx_d = idx_nxt;
                    sel_d = idx_nxt;
                    sin_d = chunks[idx_nxt];
                end
            end
            DRAIN: begin
                cap_en  = 1'b1;
                cap_idx = LAST_IDX;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (cap_en) begin
            for (int k = 0; k < NLOOK; k++) begin
                if (IDX_W'(k) == cap_idx) begin
                    res_d[OUT_W-1-NIB_W*k -: NIB_W] = sbox_out;
                end
            end
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            data_q    <= '0;
            out_data  <= '0;
            sbox_sel  <= '0;
            sbox_in   <= '0;
            sbox_req  <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            out_data  <= res_d;
            sbox_sel  <= sel_d;
            sbox_in   <= sin_d;
            sbox_req  <= (state_d == ISSUE);
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_d == DONE);
            busy      <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_des_sbox_sequencer.sv
// Directed bench for des_sbox_sequencer with a full DES S1..S8 model on the lookup port.
module tb_des_sbox_sequencer;

    localparam int unsigned PIPE_LOOKUP = 0;
    localparam int          LAT         = 8 + int'(PIPE_LOOKUP);
    localparam int          SPACING     = 10 + int'(PIPE_LOOKUP);

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] in_data;
    logic        sbox_req;
    logic [2:0]  sbox_sel;
    logic [5:0]  sbox_in;
    logic [3:0]  sbox_out;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    des_sbox_sequencer #(.PIPE_LOOKUP(PIPE_LOOKUP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .sbox_req  (sbox_req),
        .sbox_sel  (sbox_sel),
        .sbox_in   (sbox_in),
        .sbox_out  (sbox_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    // DES S-boxes, four rows of sixteen nibbles each, row 0 column 0 in the top nibble.
    function automatic logic [3:0] sbox_lookup(input logic [2:0] sel, input logic [5:0] x);
        logic [255:0] t;
        int n;
        case (sel)
            3'd0: t = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
            3'd1: t = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
            3'd2: t = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
            3'd3: t = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
            3'd4: t = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
            3'd5: t = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
            3'd6: t = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
            default: t = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;
        endcase
        n = int'({x[5], x[0]}) * 16 + int'(x[4:1]);
        return t[255-4*n -: 4];
    endfunction

    function automatic logic [31:0] model_f(input logic [47:0] w);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            r[31-4*k -: 4] = sbox_lookup(3'(k), w[47-6*k -: 6]);
        end
        return r;
    endfunction

    if (PIPE_LOOKUP != 0) begin : g_pipe
        always @(posedge clk) sbox_out <= sbox_lookup(sbox_sel, sbox_in);
    end else begin : g_comb
        assign sbox_out = sbox_lookup(sbox_sel, sbox_in);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One transaction: accept, optional lookup-sequence check, latency and result check.
    task automatic send(input logic [47:0] w, input logic [31:0] exp, input bit chk_seq,
                        input bit release_out, input string tag);
        int cnt;
        int lat;
        int k;
        in_data  = w;
        in_valid = 1'b1;
        cnt = 0;
        while (!in_ready && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, "_accept_rdy"}, 64'(in_ready), 64'(1));
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_busy"}, 64'({busy, in_ready}), 64'(2'b10));
        lat = 0;
        k   = 0;
        forever begin
            if (chk_seq && sbox_req) begin
                check({tag, "_sel"}, 64'(sbox_sel), 64'(k));
                check({tag, "_sbox_in"}, 64'(sbox_in), 64'(w[47-6*k -: 6]));
                k++;
            end
            if (out_valid || lat >= 40) break;
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(LAT));
        check({tag, "_out_data"}, 64'(out_data), 64'(exp));
        if (chk_seq) check({tag, "_nlookups"}, 64'(k), 64'(8));
        if (release_out) begin
            out_ready = 1'b1;
            @(negedge clk);
            check({tag, "_release"}, 64'({out_valid, in_ready, busy}), 64'(3'b010));
            out_ready = 1'b0;
        end
    endtask

    initial begin
        logic [47:0] words [3];
        logic [31:0] held;
        int          acc [3];
        int          cnt;

        // 1: reset
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", 64'({in_ready, out_valid, sbox_req, busy}), 64'(4'b1000));
        check("reset_data", 64'({sbox_sel, sbox_in, out_data}), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", 64'({in_ready, busy}), 64'(2'b10));

        // 2/3: directed all-zero and all-one words
        send(48'h0, 32'hEFA72C4D, 1'b0, 1'b1, "zero");
        send(48'hFFFF_FFFF_FFFF, 32'hD9CE3DCB, 1'b1, 1'b1, "ones");
        send(48'h0123_4567_89AB, model_f(48'h0123_4567_89AB), 1'b1, 1'b1, "mixed");

        // 4: backpressure in DONE, a pending word must not be taken
        send(48'hFFFF_FFFF_FFFF, 32'hD9CE3DCB, 1'b0, 1'b0, "bp");
        held     = out_data;
        in_valid = 1'b1;
        in_data  = 48'hA5A5_A5A5_A5A5;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_hold", 64'({out_valid, in_ready, out_data}), 64'({2'b10, held}));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release", 64'({out_valid, in_ready}), 64'(2'b01));
        out_ready = 1'b0;

        // 5: abort with reset during the fourth ISSUE cycle
        in_data  = 48'h1234_5678_9ABC;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_pre_sel", 64'({sbox_req, sbox_sel}), 64'(4'b1011));
        rst_n = 1'b0;
        #1;
        check("abort_reset_vals",
              64'({in_ready, out_valid, sbox_req, busy, sbox_sel, sbox_in, out_data}),
              64'({4'b1000, 3'd0, 6'd0, 32'd0}));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_after", 64'({in_ready, out_valid, busy}), 64'(3'b100));
        send(48'h0, 32'hEFA72C4D, 1'b0, 1'b1, "post_abort");

        // 6: back-to-back with in_valid held high
        for (int i = 0; i < 3; i++) words[i] = {16'($urandom), $urandom};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cnt = 0;
            while (!in_ready && cnt < 50) begin
                @(negedge clk);
                cnt++;
            end
            check("b2b_rdy", 64'(in_ready), 64'(1));
            in_data = words[i];
            acc[i]  = cyc;
            @(negedge clk);
            if (i == 2) in_valid = 1'b0;
            cnt = 0;
            while (!out_valid && cnt < 40) begin
                @(negedge clk);
                cnt++;
            end
            check("b2b_out_data", 64'(out_data), 64'(model_f(words[i])));
            if (i > 0) check("b2b_spacing", 64'(acc[i] - acc[i-1]), 64'(SPACING));
        end
        @(negedge clk);
        out_ready = 1'b0;
        check("b2b_idle", 64'({in_ready, out_valid, busy}), 64'(3'b100));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
